// File: rtl/fsm_sensor_driver_if.sv
// Connection bundle between the sensor driver, its harness and the controller FSM.
// The driver takes the master modport; the harness/FSM side takes the slave modport.
interface fsm_sensor_driver_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic             stop;
  logic             busy;
  logic             finish;
  logic             en;
  logic             ls;
  logic             rs;
  logic             done;
  logic             timeout;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] stop_cnt;
  logic [CNT_W-1:0] busy_cnt;

  modport master (
    input  start, stop, busy, finish,
    output en, ls, rs, done, timeout, cycle_cnt, stop_cnt, busy_cnt
  );

  modport slave (
    output start, stop, busy, finish,
    input  en, ls, rs, done, timeout, cycle_cnt, stop_cnt, busy_cnt
  );
endinterface

// File: rtl/fsm_sensor_driver.sv
// Closed-loop stimulus driver for the controller FSM: LFSR-driven left/right sensors,
// one-cycle hold on stop, finish/timeout termination with saturating event counters.
module fsm_sensor_driver #(
  parameter logic [7:0] LFSR_SEED = 8'hA5,
  parameter int         TIMEOUT   = 64,
  parameter int         CNT_W     = 8
) (
  input  logic                clk,
  input  logic                rst,
  fsm_sensor_driver_if.master bus
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [7:0]       SEED     = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RUN  = 3'd1,
    S_HOLD = 3'd2,
    S_DONE = 3'd3,
    S_TMO  = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [7:0]       lfsr, lfsr_nxt;
  logic [CNT_W-1:0] cycle_cnt, cycle_nxt;
  logic [CNT_W-1:0] stop_cnt, stop_nxt;
  logic [CNT_W-1:0] busy_cnt, busy_nxt;
  logic             en, ls, rs, done, timeout;
  logic             launch;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic hit);
    if (hit && (v != {CNT_W{1'b1}}))
      return v + CNT_W'(1);
    return v;
  endfunction

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  always_ff @(posedge clk) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr      <= SEED;
      cycle_cnt <= '0;
      stop_cnt  <= '0;
      busy_cnt  <= '0;
    end else begin
      lfsr      <= lfsr_nxt;
      cycle_cnt <= cycle_nxt;
      stop_cnt  <= stop_nxt;
      busy_cnt  <= busy_nxt;
    end
  end

  // Outputs use only state and lfsr; inputs affect next-state values alone.
  always_comb begin
    state_nxt = state;
    lfsr_nxt  = lfsr;
    cycle_nxt = cycle_cnt;
    stop_nxt  = stop_cnt;
    busy_nxt  = busy_cnt;
    en        = 1'b0;
    ls        = 1'b0;
    rs        = 1'b0;
    done      = 1'b0;
    timeout   = 1'b0;
    launch    = 1'b0;

    case (state)
      S_IDLE: launch = bus.start;
      S_DONE: begin
        done   = 1'b1;
        launch = bus.start;
      end
      S_TMO: begin
        timeout = 1'b1;
        launch  = bus.start;
      end
      S_RUN, S_HOLD: begin
        en        = 1'b1;
        cycle_nxt = sat_inc(cycle_cnt, 1'b1);
        stop_nxt  = sat_inc(stop_cnt, bus.stop);
        busy_nxt  = sat_inc(busy_cnt, bus.busy);
        if (state == S_RUN) begin
          ls       = lfsr[0];
          rs       = lfsr[1];
          lfsr_nxt = lfsr_step(lfsr);
        end
        if (bus.finish)
          state_nxt = S_DONE;
        else if (cycle_cnt == TMO_LAST)
          state_nxt = S_TMO;
        else if ((state == S_RUN) && bus.stop)
          state_nxt = S_HOLD;
        else
          state_nxt = S_RUN;
      end
      default: state_nxt = S_IDLE;
    endcase

    if (launch) begin
      state_nxt = S_RUN;
      lfsr_nxt  = SEED;
      cycle_nxt = '0;
      stop_nxt  = '0;
      busy_nxt  = '0;
    end
  end

  assign bus.en        = en;
  assign bus.ls        = ls;
  assign bus.rs        = rs;
  assign bus.done      = done;
  assign bus.timeout   = timeout;
  assign bus.cycle_cnt = cycle_cnt;
  assign bus.stop_cnt  = stop_cnt;
  assign bus.busy_cnt  = busy_cnt;

endmodule
